// File: rtl/conv_layer_engine.sv
// conv_layer_engine: parametrised strided/padded convolution engine.
// Walks every output window (ox fastest, then oy) and every tap in it (ch, ky, kx),
// issuing IFM and weight reads. Out-of-image taps become zeros on the fly. CHOUT
// parallel MACs accumulate the taps, then bias is added and the result is
// requantised with saturation and optional ReLU. One output pixel is strobed per window.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, relu_en  layer start (accepted in IDLE), ReLU enable latched at start
//   busy, done      layer in progress, one-cycle completion pulse
//   ifm_addr/ifm_rd_en/ifm_data   IFM read port (data one cycle after address)
//   w_addr/w_data   weight read port, all CHOUT channels per tap
//   bias            static per-channel bias
//   ofm_valid/ofm_addr/ofm_data   output pixel stream
module conv_layer_engine #(
  parameter int H_IN   = 256,
  parameter int W_IN   = 256,
  parameter int CHIN   = 3,
  parameter int CHOUT  = 64,
  parameter int KERNEL = 3,
  parameter int STRIDE = 2,
  parameter int PAD    = 1,
  parameter int WIDTH  = 16,
  parameter int ACC_W  = 32,
  parameter int FRAC   = 14,
  localparam int HOUT  = (H_IN + 2*PAD - KERNEL) / STRIDE + 1,
  localparam int WOUT  = (W_IN + 2*PAD - KERNEL) / STRIDE + 1,
  localparam int T     = KERNEL*KERNEL*CHIN,
  localparam int NPIX  = HOUT*WOUT,
  localparam int unsigned IA_W = (CHIN*H_IN*W_IN > 1) ? $clog2(CHIN*H_IN*W_IN) : 1,
  localparam int unsigned WA_W = (T > 1) ? $clog2(T) : 1,
  localparam int unsigned OA_W = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     relu_en,
  output logic                     busy,
  output logic                     done,
  output logic [IA_W-1:0]          ifm_addr,
  output logic                     ifm_rd_en,
  input  logic [WIDTH-1:0]         ifm_data,
  output logic [WA_W-1:0]          w_addr,
  input  logic [CHOUT*WIDTH-1:0]   w_data,
  input  logic [CHOUT*ACC_W-1:0]   bias,
  output logic                     ofm_valid,
  output logic [OA_W-1:0]          ofm_addr,
  output logic [CHOUT*WIDTH-1:0]   ofm_data
);

  localparam int unsigned CH_W = (CHIN > 1) ? $clog2(CHIN) : 1;
  localparam int unsigned K_W  = (KERNEL > 1) ? $clog2(KERNEL) : 1;
  localparam int unsigned OX_W = (WOUT > 1) ? $clog2(WOUT) : 1;
  localparam int unsigned OY_W = (HOUT > 1) ? $clog2(HOUT) : 1;

  localparam logic signed [ACC_W-1:0] QMAX = ACC_W'((64'sd1 <<< (WIDTH-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] QMIN = ~QMAX;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state, state_nx;
  logic   issue_c;

  // Tap/window walk counters (point at the tap issued next)
  logic [CH_W-1:0] ch;
  logic [K_W-1:0]  ky, kx;
  logic [OX_W-1:0] ox;
  logic [OY_W-1:0] oy;
  logic [WA_W-1:0] t;
  logic [OA_W-1:0] pix;
  logic            relu_q;

  int   iy_c, ix_c, addr_c;
  logic in_range_c, last_tap_c, last_win_c;

  // Issue stage, aligned with the address outputs
  logic            tap_vld, tap_first, tap_last, tap_pad;
  logic [OA_W-1:0] tap_pix;
  // Data stage, aligned with ifm_data/w_data
  logic            d_vld, d_first, d_last, d_pad;
  logic [OA_W-1:0] d_pix;
  // Requant stage, final accumulator visible
  logic            r_vld;
  logic [OA_W-1:0] r_pix;

  logic signed [ACC_W-1:0]   acc     [CHOUT];
  logic signed [WIDTH-1:0]   px_c;
  logic signed [2*WIDTH-1:0] mul_c   [CHOUT];
  logic signed [ACC_W-1:0]   prod_c  [CHOUT];
  logic signed [ACC_W-1:0]   sum_c   [CHOUT];
  logic signed [ACC_W-1:0]   q_c     [CHOUT];
  logic signed [ACC_W-1:0]   sat_c   [CHOUT];
  logic [CHOUT*WIDTH-1:0]    rq_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state and tap-issue strobe
  always_comb begin
    state_nx = state;
    issue_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          issue_c  = 1'b1;
          state_nx = (last_tap_c && last_win_c) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        issue_c = 1'b1;
        if (last_tap_c && last_win_c) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (ofm_valid && ofm_addr == OA_W'(NPIX-1)) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Tap geometry for the current counters
  always_comb begin
    iy_c       = int'(oy)*STRIDE + int'(ky) - PAD;
    ix_c       = int'(ox)*STRIDE + int'(kx) - PAD;
    in_range_c = (iy_c >= 0) && (iy_c < H_IN) && (ix_c >= 0) && (ix_c < W_IN);
    addr_c     = int'(ch)*H_IN*W_IN + iy_c*W_IN + ix_c;
    last_tap_c = (t == WA_W'(T-1));
    last_win_c = (ox == OX_W'(WOUT-1)) && (oy == OY_W'(HOUT-1));
  end

  // Status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nx != S_IDLE);
      done <= (state_nx == S_DONE);
    end
  end

  // Address generation and tap walk; ifm_addr freezes on padded taps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch        <= '0;
      ky        <= '0;
      kx        <= '0;
      ox        <= '0;
      oy        <= '0;
      t         <= '0;
      pix       <= '0;
      relu_q    <= 1'b0;
      ifm_addr  <= '0;
      ifm_rd_en <= 1'b0;
      w_addr    <= '0;
      tap_vld   <= 1'b0;
      tap_first <= 1'b0;
      tap_last  <= 1'b0;
      tap_pad   <= 1'b0;
      tap_pix   <= '0;
    end else begin
      tap_vld   <= issue_c;
      ifm_rd_en <= issue_c && in_range_c;
      if (state == S_IDLE && start) relu_q <= relu_en;
      if (issue_c) begin
        w_addr    <= t;
        tap_first <= (t == '0);
        tap_last  <= last_tap_c;
        tap_pad   <= !in_range_c;
        tap_pix   <= pix;
        if (in_range_c) ifm_addr <= IA_W'(addr_c);
        if (kx == K_W'(KERNEL-1)) begin
          kx <= '0;
          if (ky == K_W'(KERNEL-1)) begin
            ky <= '0;
            if (ch == CH_W'(CHIN-1)) ch <= '0;
            else                     ch <= ch + 1'b1;
          end else begin
            ky <= ky + 1'b1;
          end
        end else begin
          kx <= kx + 1'b1;
        end
        t <= last_tap_c ? '0 : t + 1'b1;
        if (last_tap_c) begin
          if (last_win_c) begin
            ox  <= '0;
            oy  <= '0;
            pix <= '0;
          end else begin
            pix <= pix + 1'b1;
            if (ox == OX_W'(WOUT-1)) begin
              ox <= '0;
              oy <= oy + 1'b1;
            end else begin
              ox <= ox + 1'b1;
            end
          end
        end
      end
    end
  end

  // Products: padded taps contribute zero regardless of the read data
  always_comb begin
    px_c = d_pad ? '0 : $signed(ifm_data);
    for (int i = 0; i < CHOUT; i++) begin
      mul_c[i]  = (2*WIDTH)'(px_c) * (2*WIDTH)'($signed(w_data[i*WIDTH +: WIDTH]));
      prod_c[i] = ACC_W'(mul_c[i]);
    end
  end

  // Bias, arithmetic shift, ReLU and saturation per channel
  always_comb begin
    rq_c = '0;
    for (int i = 0; i < CHOUT; i++) begin
      sum_c[i] = acc[i] + $signed(bias[i*ACC_W +: ACC_W]);
      q_c[i]   = sum_c[i] >>> FRAC;
      if (relu_q && sum_c[i][ACC_W-1]) sat_c[i] = '0;
      else if (q_c[i] > QMAX)          sat_c[i] = QMAX;
      else if (q_c[i] < QMIN)          sat_c[i] = QMIN;
      else                             sat_c[i] = q_c[i];
      rq_c[i*WIDTH +: WIDTH] = sat_c[i][WIDTH-1:0];
    end
  end

  // Data-stage pipeline and accumulators (tap 0 overwrites, others add)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_vld   <= 1'b0;
      d_first <= 1'b0;
      d_last  <= 1'b0;
      d_pad   <= 1'b0;
      d_pix   <= '0;
      r_vld   <= 1'b0;
      r_pix   <= '0;
      for (int i = 0; i < CHOUT; i++) acc[i] <= '0;
    end else begin
      d_vld   <= tap_vld;
      d_first <= tap_first;
      d_last  <= tap_last;
      d_pad   <= tap_pad;
      d_pix   <= tap_pix;
      r_vld   <= d_vld && d_last;
      if (d_vld && d_last) r_pix <= d_pix;
      if (d_vld) begin
        for (int i = 0; i < CHOUT; i++)
          acc[i] <= d_first ? prod_c[i] : acc[i] + prod_c[i];
      end
    end
  end

  // Output registers hold until the next strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ofm_valid <= 1'b0;
      ofm_addr  <= '0;
      ofm_data  <= '0;
    end else begin
      ofm_valid <= r_vld;
      if (r_vld) begin
        ofm_addr <= r_pix;
        ofm_data <= rq_c;
      end
    end
  end

endmodule

// File: tb/tb_conv_layer_engine.sv
// Self-checking bench for conv_layer_engine (4x4x1 image, 2 output channels, 3x3 kernel,
// stride 1, pad 1). A behavioural model computes every expected pixel by direct
// summation; one compare process checks addresses, strobes and data cycle by cycle.
module tb_conv_layer_engine;
  localparam int H = 4, W = 4, CI = 1, CO = 2, K = 3, S = 1, P = 1;
  localparam int WD = 16, AW = 32, FR = 14;
  localparam int HO = (H + 2*P - K) / S + 1;
  localparam int WO = (W + 2*P - K) / S + 1;
  localparam int T = K*K*CI;
  localparam int NP = HO*WO;
  localparam int DONE_N = T*NP + 3;

  logic clk = 1'b0;
  logic rst, start, relu_en;
  logic busy, done, ifm_rd_en, ofm_valid;
  logic [3:0] ifm_addr, w_addr, ofm_addr;
  logic [WD-1:0] ifm_data;
  logic [CO*WD-1:0] w_data, ofm_data;
  logic [CO*AW-1:0] bias;

  logic signed [WD-1:0] img [16];
  logic signed [WD-1:0] wt  [16][CO];
  logic signed [AW-1:0] bs  [CO];
  logic signed [WD-1:0] exp_d [NP][CO];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, first_tap = 0, last_k = -1, cn, ck;
  bit active = 0, run_over = 0, ex_v;
  int tt, ww, tch, tky, tkx, tox, toy, tiy, tix;
  bit inr;

  conv_layer_engine #(
    .H_IN(H), .W_IN(W), .CHIN(CI), .CHOUT(CO), .KERNEL(K), .STRIDE(S), .PAD(P),
    .WIDTH(WD), .ACC_W(AW), .FRAC(FR)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en), .busy(busy), .done(done),
    .ifm_addr(ifm_addr), .ifm_rd_en(ifm_rd_en), .ifm_data(ifm_data),
    .w_addr(w_addr), .w_data(w_data), .bias(bias),
    .ofm_valid(ofm_valid), .ofm_addr(ofm_addr), .ofm_data(ofm_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int co = 0; co < CO; co++) bias[co*AW +: AW] = bs[co];
  end

  // Memories: one-cycle read latency; garbage on non-enabled IFM cycles
  always @(posedge clk) begin
    ifm_data <= ifm_rd_en ? img[ifm_addr] : WD'($urandom);
    for (int co = 0; co < CO; co++) w_data[co*WD +: WD] <= wt[w_addr][co];
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic logic signed [WD-1:0] requant(input longint a, input longint b, input bit relu);
    logic signed [AW-1:0] s;
    longint q;
    s = AW'(a + b);
    q = longint'(s) >>> FR;
    if (relu && s < 0) return '0;
    if (q > 32767) return 16'sd32767;
    if (q < -32768) return -16'sd32768;
    return WD'(q);
  endfunction

  task automatic build_model(input bit relu);
    for (int oy = 0; oy < HO; oy++)
      for (int ox = 0; ox < WO; ox++)
        for (int co = 0; co < CO; co++) begin
          longint a = 0;
          for (int ch = 0; ch < CI; ch++)
            for (int ky = 0; ky < K; ky++)
              for (int kx = 0; kx < K; kx++) begin
                int iy = oy*S + ky - P, ix = ox*S + kx - P;
                if (iy >= 0 && iy < H && ix >= 0 && ix < W)
                  a += longint'(img[ch*H*W + iy*W + ix]) * longint'(wt[ch*K*K + ky*K + kx][co]);
              end
          exp_d[oy*WO + ox][co] = requant(a, longint'(bs[co]), relu);
        end
  endtask

  // Cycle-by-cycle compare against the model; cn counts cycles from the first tap
  always @(negedge clk) begin
    if (active && !run_over) begin
      cn = cyc - first_tap;
      chk("busy", busy, cn <= DONE_N);
      chk("done", done, cn == DONE_N);
      ex_v = (cn >= T+2) && ((cn-T-2) % T == 0) && ((cn-T-2)/T < NP);
      chk("ofm_valid", ofm_valid, ex_v);
      if (ex_v) begin
        ck = (cn-T-2)/T;
        chk("ofm_addr", longint'(ofm_addr), ck);
        for (int co = 0; co < CO; co++)
          chk("ofm_data", longint'($signed(ofm_data[co*WD +: WD])), longint'(exp_d[ck][co]));
        last_k = ck;
      end else if (last_k >= 0) begin
        for (int co = 0; co < CO; co++)
          chk("ofm_hold", longint'($signed(ofm_data[co*WD +: WD])), longint'(exp_d[last_k][co]));
      end
      if (cn < T*NP) begin
        tt = cn % T;  ww = cn / T;
        tch = tt / (K*K);  tky = (tt / K) % K;  tkx = tt % K;
        tox = ww % WO;  toy = ww / WO;
        tiy = toy*S + tky - P;  tix = tox*S + tkx - P;
        inr = (tiy >= 0) && (tiy < H) && (tix >= 0) && (tix < W);
        chk("ifm_rd_en", ifm_rd_en, inr);
        chk("w_addr", longint'(w_addr), tt);
        if (inr) chk("ifm_addr", longint'(ifm_addr), tch*H*W + tiy*W + tix);
      end else begin
        chk("ifm_rd_en_idle", ifm_rd_en, 0);
      end
      if (cn == DONE_N + 2) run_over = 1;
    end
  end

  task automatic run_layer(input bit relu, input bit poke);
    build_model(relu);
    relu_en = relu;
    start = 1;
    @(posedge clk); #2;
    start = 0;
    first_tap = cyc;
    last_k = -1;
    run_over = 0;
    active = 1;
    for (int i = 0; i < 400 && !run_over; i++) begin
      @(posedge clk); #2;
      start = (poke && i == 20);
    end
    start = 0;
    if (!run_over) begin
      n_cmp++; n_bad++;
      $display("FAIL run_timeout: got no completion, expected done within 400 cycles");
    end
    active = 0;
  endtask

  task automatic fill_const(input int pv, input int wv, input int bv);
    for (int i = 0; i < 16; i++) img[i] = WD'(pv);
    for (int i = 0; i < 16; i++) for (int co = 0; co < CO; co++) wt[i][co] = WD'(wv);
    for (int co = 0; co < CO; co++) bs[co] = AW'(bv);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) img[i] = WD'($urandom);
    for (int i = 0; i < 16; i++)
      for (int co = 0; co < CO; co++) wt[i][co] = WD'($urandom_range(0, 8191)) - 16'sd4096;
    for (int co = 0; co < CO; co++) bs[co] = $signed(AW'($urandom)) >>> 6;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected bench completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; start = 0; relu_en = 0;
    fill_const(0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ofm_valid", ofm_valid, 0);
    chk("rst_rd_en", ifm_rd_en, 0);
    chk("rst_ofm_data", longint'(ofm_data), 0);
    @(posedge clk); #2 rst = 0;
    repeat (2) @(posedge clk); #2;

    // Uniform image, positive weights; start poked mid-run
    fill_const(1024, 16384, 0);
    run_layer(0, 1);
    chk("pin_corner", longint'(exp_d[0][0]), 4096);
    chk("pin_interior", longint'(exp_d[5][1]), 9216);

    fill_const(1024, -16384, 0);
    run_layer(0, 0);
    chk("pin_neg_corner", longint'(exp_d[0][1]), -4096);
    chk("pin_neg_interior", longint'(exp_d[5][0]), -9216);
    run_layer(1, 0);
    chk("pin_relu", longint'(exp_d[5][0]), 0);

    fill_const(1024, 16384, 1 << 30);
    run_layer(0, 0);
    chk("pin_sat_hi", longint'(exp_d[0][0]), 32767);
    fill_const(1024, 16384, -(1 << 30));
    run_layer(0, 0);
    chk("pin_sat_lo", longint'(exp_d[5][1]), -32768);

    // Abort during window 7, then rerun from pixel 0
    fill_rand();
    relu_en = 0;
    start = 1;
    @(posedge clk); #2 start = 0;
    repeat (7*T + 3) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", ofm_valid, 0);
    chk("abort_rd_en", ifm_rd_en, 0);
    chk("abort_ofm_addr", longint'(ofm_addr), 0);
    repeat (2) @(posedge clk);
    #2 rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_abort_valid", ofm_valid, 0);
      chk("post_abort_done", done, 0);
    end
    @(posedge clk); #2;
    run_layer(0, 0);

    for (int r = 0; r < 3; r++) begin
      fill_rand();
      run_layer(bit'($urandom_range(0, 1)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
